derandomizer_deframer: RTL and testbench

Receive-side counterpart of the Randomizer. It takes the randomized serial bit stream and removes the PRBS by XOR with the same 15-stage LFSR (1 + x^14 + x^15), reseeded at each frame start. It then packs the recovered bits MSB-first into 96-bit blocks and hands each block out through a one-deep valid/ready buffer. It sits between the serial link / Randomizer output and the parallel block consumer.

---
 rtl/derandomizer_deframer.sv | 170 +++++++++++++++++
 tb/tb_derandomizer_deframer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/derandomizer_deframer.sv
`default_nettype none
// ============================================================================
// Module   : derandomizer_deframer
// Purpose  : Strips the 1 + x^14 + x^15 PRBS from a randomized serial stream
//            and packs the recovered bits, MSB first, into BLOCK_BITS-wide
//            blocks handed out through a one-deep valid/ready buffer.
// Revision : 1.0 - initial release
// ============================================================================
module derandomizer_deframer #(
  parameter int BLOCK_BITS       = 96,
  parameter bit RESEED_PER_BLOCK = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,      // asynchronous, active low
  input  logic [14:0]           seed,
  input  logic                  in_bit,
  input  logic                  in_sof,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BLOCK_BITS-1:0] blk_data,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic                  sync_err
);

  localparam int                CNT_W    = $clog2(BLOCK_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // waiting for the first start-of-frame
    ST_RUN  = 2'd1,   // collecting bits of a block
    ST_FULL = 2'd2    // a finished block waits in sh for the buffer
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [14:0]             lfsr;
  logic [BLOCK_BITS-1:0]   sh;
  logic [CNT_W-1:0]        cnt;

  // Handshake and per-bit control terms
  logic                    accept;      // bit transferred this edge
  logic                    take;        // accepted bit enters the block
  logic                    reload;      // LFSR restarts from seed on this bit
  logic                    resync;      // start-of-frame inside a partial block
  logic                    last;        // accepted bit completes a block
  logic                    drain;       // consumer takes the buffered block
  logic                    buf_free;    // buffer can take a block this edge
  logic                    load_new;    // completed block goes straight to buffer
  logic                    load_held;   // block parked in sh moves to buffer

  // Descrambler datapath
  logic [14:0]             lfsr_src;
  logic                    fb;
  logic                    d;
  logic [BLOCK_BITS-1:0]   full_block;

  // The input side stalls only while a completed block is parked in sh.
  assign in_ready = (state != ST_FULL);

  assign accept   = in_valid & in_ready;
  // In IDLE only a start-of-frame bit is meaningful; everything else is noise.
  assign take     = accept & ((state == ST_RUN) | in_sof);
  assign reload   = take & (in_sof | (RESEED_PER_BLOCK & (cnt == '0)));
  // A start-of-frame at cnt 0 is just an aligned reload, not a framing error.
  assign resync   = accept & in_sof & (state == ST_RUN) & (cnt != '0);
  assign last     = take & ~in_sof & (state == ST_RUN) & (cnt == CNT_LAST);

  assign drain    = blk_valid & blk_ready;
  assign buf_free = ~blk_valid | blk_ready;
  assign load_new = last & buf_free;
  assign load_held = (state == ST_FULL) & drain;

  // On a reload the keystream bit is generated from the seed itself, so the
  // very first bit of the frame is already descrambled correctly.
  assign lfsr_src   = reload ? seed : lfsr;
  assign fb         = lfsr_src[1] ^ lfsr_src[0];
  assign d          = in_bit ^ fb;
  assign full_block = {sh[BLOCK_BITS-2:0], d};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last && !buf_free) begin
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // LFSR advance, bit packing and position counter; all frozen without a take
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= '0;
      sh   <= '0;
      cnt  <= '0;
    end else begin
      if (take) begin
        lfsr <= {fb, lfsr_src[14:1]};
        sh   <= full_block;
        if (in_sof) begin
          // The start-of-frame bit is bit 0 of a new block; older bits in sh
          // are shifted out before they can ever be delivered.
          cnt <= CNT_ONE;
        end else if (cnt == CNT_LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else if (load_held) begin
        cnt <= '0;
      end
    end
  end

  // One-deep output buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_data  <= '0;
      blk_valid <= 1'b0;
    end else begin
      if (load_new) begin
        blk_data  <= full_block;
        blk_valid <= 1'b1;
      end else if (load_held) begin
        blk_data  <= sh;
        blk_valid <= 1'b1;
      end else if (drain) begin
        blk_valid <= 1'b0;
      end
    end
  end

  // Registered single-cycle framing error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= resync;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_derandomizer_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_derandomizer_deframer
// Purpose  : Self-checking bench for derandomizer_deframer with a bit-level
//            reference model feeding a block scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_derandomizer_deframer;

  localparam int BB     = 96;
  localparam bit RESEED = 1'b1;

  logic          clk = 1'b0;
  logic          reset;
  logic [14:0]   seed;
  logic          in_bit;
  logic          in_sof;
  logic          in_valid;
  logic          in_ready;
  logic [BB-1:0] blk_data;
  logic          blk_valid;
  logic          blk_ready;
  logic          sync_err;

  always #5 clk = ~clk;

  derandomizer_deframer #(
    .BLOCK_BITS       (BB),
    .RESEED_PER_BLOCK (RESEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed      (seed),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .sync_err  (sync_err)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Stages numbered 1..15 as in the polynomial; feedback taps stages 14 and 15.
  bit            st [1:15];
  bit            m_bits [$];
  bit            m_in_frame;
  logic [BB-1:0] exp_q [$];
  int            exp_err = 0;

  task automatic model_reset();
    exp_q.delete();
    m_bits.delete();
    m_in_frame = 1'b0;
    for (int k = 1; k <= 15; k++) st[k] = 1'b0;
  endtask

  task automatic model_accept(input logic b, input logic sof);
    bit            fbit;
    logic [BB-1:0] blk;
    if (!m_in_frame && !sof) return;
    if (sof && m_in_frame && m_bits.size() != 0) exp_err++;
    if (sof) m_bits.delete();
    m_in_frame = 1'b1;
    if (sof || (RESEED && m_bits.size() == 0)) begin
      for (int k = 1; k <= 15; k++) st[k] = seed[15-k];
    end
    fbit = st[14] ^ st[15];
    for (int k = 15; k >= 2; k--) st[k] = st[k-1];
    st[1] = fbit;
    m_bits.push_back(b ^ fbit);
    if (m_bits.size() == BB) begin
      for (int i = 0; i < BB; i++) blk[BB-1-i] = m_bits[i];
      exp_q.push_back(blk);
      m_bits.delete();
    end
  endtask

  // ---------------- monitor ----------------
  int            cycle = 0;
  int            obs_err = 0;
  logic          prev_err = 1'b0;
  bit            held_v = 1'b0;
  logic [BB-1:0] held_d;
  logic [BB-1:0] sb_exp;
  int            pop_cycles [$];
  bit            watch_ready = 1'b0;
  int            ready_low = 0;

  always @(negedge clk) begin
    cycle++;
    if (reset !== 1'b1) begin
      held_v   = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (sync_err) begin
        obs_err++;
        chk("sync_err_width", prev_err, 0);
      end
      prev_err = sync_err;
      if (watch_ready && !in_ready) ready_low++;
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_block: got %h expected none", blk_data);
        end else begin
          sb_exp = exp_q.pop_front();
          chk("block_data", blk_data, sb_exp);
        end
        pop_cycles.push_back(cycle);
        held_v = 1'b0;
      end else if (blk_valid) begin
        if (held_v) chk("held_stable", blk_data, held_d);
        held_v = 1'b1;
        held_d = blk_data;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  logic [BB-1:0] vec_in;
  logic [BB-1:0] vec_out;

  task automatic send_bit(input logic b, input logic sof, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    in_bit   = b;
    in_sof   = sof;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(b, sof);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_vec(input bit sof, input bit gaps);
    for (int i = BB - 1; i >= 0; i--) send_bit(vec_in[i], sof && (i == BB - 1), gaps);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_blk_valid"}, blk_valid, 0);
    chk({tag, "_blk_data"},  blk_data,  0);
    chk({tag, "_sync_err"},  sync_err,  0);
  endtask

  task automatic do_reset(input string tag);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  bit rand_done = 1'b0;

  initial begin
    int n0;
    int e0;
    bit prev_sof;
    bit s;

    vec_in    = 96'h558AC4A53A1724E163AC2BF9;
    vec_out   = 96'hACBCD2114DAE1577C6DBF4C9;
    reset     = 1'b0;
    in_bit    = 1'b0;
    in_sof    = 1'b0;
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    seed      = 15'h3715;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reference vector, single block
    send_vec(1'b1, 1'b0);
    chk("t1_valid_latency", blk_valid, 1);
    chk("t1_data", blk_data, vec_out);
    wait_drain("t1_drain");
    chk("t1_sync_err", obs_err, 0);

    // Back-to-back blocks with per-block reseed
    watch_ready = 1'b1;
    n0 = pop_cycles.size();
    send_vec(1'b1, 1'b0);
    send_vec(1'b0, 1'b0);
    chk("t2_data", blk_data, vec_out);
    wait_drain("t2_drain");
    watch_ready = 1'b0;
    chk("t2_ready_low", ready_low, 0);
    if (pop_cycles.size() >= n0 + 2) begin
      chk("t2_spacing", pop_cycles[n0+1] - pop_cycles[n0], BB);
    end else begin
      checks++;
      fails++;
      $display("FAIL t2_block_count: got %0d expected 2", pop_cycles.size() - n0);
    end

    // Back-pressure: two blocks with blk_ready low
    blk_ready = 1'b0;
    send_vec(1'b1, 1'b0);
    send_vec(1'b0, 1'b0);
    chk("t3_in_ready_low", in_ready, 0);
    chk("t3_block1_valid", blk_valid, 1);
    chk("t3_block1_data", blk_data, vec_out);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_still_stalled", in_ready, 0);
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    chk("t3_block2_valid", blk_valid, 1);
    chk("t3_block2_data", blk_data, vec_out);
    chk("t3_ready_back", in_ready, 1);
    blk_ready = 1'b1;
    wait_drain("t3_drain");

    // Mid-block resync at bit 40
    e0 = obs_err;
    send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    for (int i = 1; i < 40; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    send_vec(1'b1, 1'b0);
    chk("t4_data", blk_data, vec_out);
    wait_drain("t4_drain");
    chk("t4_sync_err_count", obs_err - e0, 1);
    chk("t4_err_model", obs_err, exp_err);

    // Reset mid-block
    send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    for (int i = 1; i < 50; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    do_reset("rst_mid");
    send_vec(1'b1, 1'b0);
    chk("t5_fresh_data", blk_data, vec_out);
    wait_drain("t5_drain");

    // Reset while stalled in FULL
    blk_ready = 1'b0;
    send_vec(1'b1, 1'b0);
    send_vec(1'b0, 1'b0);
    chk("t5_full_reached", in_ready, 0);
    do_reset("rst_full");
    blk_ready = 1'b1;

    // Pre-sync garbage then the vector with input gaps
    for (int i = 0; i < 17; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("t6_garbage_ignored", blk_valid, 0);
    send_vec(1'b1, 1'b1);
    chk("t6_data", blk_data, vec_out);
    wait_drain("t6_drain");

    // Randomized stream, seed, framing, gaps and back-pressure
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          if (!rand_done) blk_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    seed = 15'($urandom);
    send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    prev_sof = 1'b1;
    for (int i = 0; i < 700; i++) begin
      s = !prev_sof && ($urandom_range(0, 59) == 0);
      send_bit(1'($urandom_range(0, 1)), s, 1'b1);
      prev_sof = s;
    end
    rand_done = 1'b1;
    @(posedge clk);
    #2;
    blk_ready = 1'b1;
    wait_drain("t7_drain");
    chk("t7_err_model", obs_err, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
